// File: rtl/spaceinv_pkg.sv
// Shared definitions for the space-invaders blocks (ship, alien, player missile):
// coordinate width, screen limits, colour constants and the missile FSM states.
package spaceinv_pkg;

    localparam int COORD_W = 11;

    // Playfield vertical limits
    localparam int TOP_Y   = 40;
    localparam int START_Y = 490;

    // 24-bit colours packed as {R, G, B}
    localparam logic [23:0] WHITE  = 24'hFF_FF_FF;
    localparam logic [23:0] YELLOW = 24'hFF_FF_00;
    localparam logic [23:0] BLACK  = 24'h00_00_00;

    // Explosion sprite geometry (square, centred on the hit position)
    localparam int EXP_SIZE  = 6;
    localparam int EXP_STEPS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        EXPLODE = 2'd2
    } missile_state_t;

endpackage

// File: rtl/municao_jogador_pulso_passo.sv
// pulso_passo: free-running modulo-DELAY counter that emits a one-cycle pulse
// on its last count. Shared by the player missile and the alien bullet blocks.
module pulso_passo #(
    parameter int DELAY = 200000
) (
    input  logic clk,
    input  logic reset,
    output logic pulse
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Wrap back to zero after the last count
    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
            cnt_next = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign pulse = (cnt_reg == LAST);

endmodule

// File: rtl/municao_jogador.sv
// municao_jogador: player missile. Launches one missile from the ship nose on a
// rising edge of fire, moves it up SPEED pixels every STEP_DELAY cycles, retires
// it at the top of the playfield or on a hit, and renders its own pixels.
// Optional macro MUNICAO_EXPLOSAO_EN: after a hit, shows a yellow 6x6 block
// centred on the hit position for 8 step pulses before returning to IDLE.
module municao_jogador
    import spaceinv_pkg::*;
#(
    parameter int COORD_W_P  = COORD_W,
    parameter int STEP_DELAY = 200000,
    parameter int SPEED      = 4,
    parameter int START_ROW  = START_Y,
    parameter int TOP_ROW    = TOP_Y,
    parameter int NOSE_OFS   = 10,
    parameter int MIS_W      = 2,
    parameter int MIS_H      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fire,
    input  logic [COORD_W_P-1:0] posX_Nave,
    input  logic                 hit,
    input  logic [9:0]           h_counter,
    input  logic [9:0]           v_counter,
    output logic [COORD_W_P-1:0] posX_Municao,
    output logic [COORD_W_P-1:0] posY_Municao,
    output logic                 ativo,
    output logic [7:0]           R,
    output logic [7:0]           G,
    output logic [7:0]           B
);

    localparam logic [COORD_W_P-1:0] NOSE_C    = COORD_W_P'(NOSE_OFS);
    localparam logic [COORD_W_P-1:0] SPAWN_Y   = COORD_W_P'(START_ROW - MIS_H);
    localparam logic [COORD_W_P-1:0] RETIRE_Y  = COORD_W_P'(TOP_ROW + SPEED);
    localparam logic [COORD_W_P-1:0] SPEED_C   = COORD_W_P'(SPEED);
    localparam logic [COORD_W_P-1:0] MIS_W_C   = COORD_W_P'(MIS_W);
    localparam logic [COORD_W_P-1:0] MIS_H_C   = COORD_W_P'(MIS_H);

    missile_state_t state_reg, state_next;

    logic                 fire_d_reg;
    logic                 launch_reg;
    logic [COORD_W_P-1:0] posx_reg, posx_next;
    logic [COORD_W_P-1:0] posy_reg, posy_next;
    logic                 ativo_reg, ativo_next;
    logic [23:0]          rgb_reg, rgb_next;
    logic                 step;

    // Beam position widened to coordinate width for the compares
    logic [COORD_W_P-1:0] h_pos;
    logic [COORD_W_P-1:0] v_pos;
    assign h_pos = COORD_W_P'(h_counter);
    assign v_pos = COORD_W_P'(v_counter);

`ifdef MUNICAO_EXPLOSAO_EN
    localparam logic [COORD_W_P-1:0] EXP_HALF = COORD_W_P'(EXP_SIZE / 2);
    localparam logic [3:0]           EXP_LAST = 4'(EXP_STEPS - 1);

    logic [COORD_W_P-1:0] expx_reg, expx_next;
    logic [COORD_W_P-1:0] expy_reg, expy_next;
    logic [3:0]           exp_cnt_reg, exp_cnt_next;
`endif

    pulso_passo #(
        .DELAY (STEP_DELAY)
    ) u_pulso_passo (
        .clk   (clk),
        .reset (reset),
        .pulse (step)
    );

    // Fire edge detection; the launch request is registered so the FSM acts
    // one cycle after the edge is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_d_reg <= 1'b0;
            launch_reg <= 1'b0;
        end else begin
            fire_d_reg <= fire;
            launch_reg <= fire & ~fire_d_reg;
        end
    end

    // State and missile datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            posx_reg  <= '0;
            posy_reg  <= '0;
            ativo_reg <= 1'b0;
`ifdef MUNICAO_EXPLOSAO_EN
            expx_reg    <= '0;
            expy_reg    <= '0;
            exp_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            posx_reg  <= posx_next;
            posy_reg  <= posy_next;
            ativo_reg <= ativo_next;
`ifdef MUNICAO_EXPLOSAO_EN
            expx_reg    <= expx_next;
            expy_reg    <= expy_next;
            exp_cnt_reg <= exp_cnt_next;
`endif
        end
    end

    // Next-state logic: launch, climb, retire, hit (hit beats a coincident step)
    always_comb begin
        state_next = state_reg;
        posx_next  = posx_reg;
        posy_next  = posy_reg;
        ativo_next = ativo_reg;
`ifdef MUNICAO_EXPLOSAO_EN
        expx_next    = expx_reg;
        expy_next    = expy_reg;
        exp_cnt_next = exp_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (launch_reg) begin
                    posx_next  = posX_Nave + NOSE_C;
                    posy_next  = SPAWN_Y;
                    ativo_next = 1'b1;
                    state_next = FLY;
                end
            end
            FLY: begin
                if (hit) begin
                    ativo_next = 1'b0;
                    posy_next  = '0;
`ifdef MUNICAO_EXPLOSAO_EN
                    expx_next    = posx_reg;
                    expy_next    = posy_reg;
                    exp_cnt_next = '0;
                    state_next   = EXPLODE;
`else
                    state_next = IDLE;
`endif
                end else if (step) begin
                    // Retiring before the subtraction keeps Y from wrapping
                    if (posy_reg <= RETIRE_Y) begin
                        ativo_next = 1'b0;
                        posy_next  = '0;
                        state_next = IDLE;
                    end else begin
                        posy_next = posy_reg - SPEED_C;
                    end
                end
            end
`ifdef MUNICAO_EXPLOSAO_EN
            EXPLODE: begin
                if (step) begin
                    if (exp_cnt_reg == EXP_LAST) begin
                        exp_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        exp_cnt_next = exp_cnt_reg + 4'd1;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
                ativo_next = 1'b0;
                posy_next  = '0;
            end
        endcase
    end

    // Pixel colour for the current beam position
    always_comb begin
        rgb_next = BLACK;
        if (ativo_reg
            && h_pos >= posx_reg && h_pos < posx_reg + MIS_W_C
            && v_pos >= posy_reg && v_pos < posy_reg + MIS_H_C) begin
            rgb_next = WHITE;
        end
`ifdef MUNICAO_EXPLOSAO_EN
        // Written as h+half >= x to avoid underflow near the left/top edge
        if (state_reg == EXPLODE
            && h_pos + EXP_HALF >= expx_reg && h_pos < expx_reg + EXP_HALF
            && v_pos + EXP_HALF >= expy_reg && v_pos < expy_reg + EXP_HALF) begin
            rgb_next = YELLOW;
        end
`endif
    end

    // Registered pixel output, one cycle behind the beam counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_reg <= BLACK;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign posX_Municao = posx_reg;
    assign posY_Municao = posy_reg;
    assign ativo        = ativo_reg;
    assign R            = rgb_reg[23:16];
    assign G            = rgb_reg[15:8];
    assign B            = rgb_reg[7:0];

endmodule

// File: tb/tb_municao_jogador.sv
// Directed bench for municao_jogador with STEP_DELAY=4, SPEED=4, TOP_Y=40.
// Edge k counts rising clock edges after reset release; steps land on k%4==0.
module tb_municao_jogador;

    logic        clk;
    logic        reset;
    logic        fire;
    logic [10:0] posX_Nave;
    logic        hit;
    logic [9:0]  h_counter;
    logic [9:0]  v_counter;
    logic [10:0] posX_Municao;
    logic [10:0] posY_Municao;
    logic        ativo;
    logic [7:0]  R, G, B;

    int n_vec;
    int n_bad;
    int k;
    int y_now;

    municao_jogador #(
        .STEP_DELAY (4),
        .SPEED      (4),
        .TOP_ROW    (40)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fire         (fire),
        .posX_Nave    (posX_Nave),
        .hit          (hit),
        .h_counter    (h_counter),
        .v_counter    (v_counter),
        .posX_Municao (posX_Municao),
        .posY_Municao (posY_Municao),
        .ativo        (ativo),
        .R            (R),
        .G            (G),
        .B            (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end else begin
            $display("ok   %s: %0h (edge %0d)", tag, got, k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        #1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; k = 0;
        reset = 1'b1; fire = 1'b0; hit = 1'b0; posX_Nave = 11'd445;
        h_counter = '0; v_counter = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ativo", 32'(ativo), 32'd0);
        chk("rst_posx", 32'(posX_Municao), 32'd0);
        chk("rst_posy", 32'(posY_Municao), 32'd0);
        chk("rst_rgb", 32'({R, G, B}), 32'h000000);

        // Launch: edge registered at k=1, outputs update at k=2
        reset = 1'b0; k = 0;
        fire = 1'b1;
        tick();
        chk("prelaunch_ativo", 32'(ativo), 32'd0);
        tick();
        chk("launch_ativo", 32'(ativo), 32'd1);
        chk("launch_posx", 32'(posX_Municao), 32'd455);
        chk("launch_posy", 32'(posY_Municao), 32'd482);

        // Fire held and ship moving: single launch, steady climb, X frozen
        posX_Nave = 11'd500;
        while (k < 100) begin
            tick();
            if (k % 16 == 0) chk("climb_posy", 32'(posY_Municao), 32'(482 - 4 * (k / 4)));
        end
        chk("hold_posx", 32'(posX_Municao), 32'd455);
        chk("hold_ativo", 32'(ativo), 32'd1);

        // Pixel scan over the missile body
        for (int i = 0; i < 16; i++) begin
            y_now = 482 - 4 * (k / 4);
            h_counter = 10'(455 + i % 2);
            v_counter = 10'(y_now + i / 2);
            tick();
            chk("pix_white", 32'({R, G, B}), 32'hFFFFFF);
        end
        y_now = 482 - 4 * (k / 4);
        h_counter = 10'd457; v_counter = 10'(y_now);
        tick();
        chk("pix_right", 32'({R, G, B}), 32'h000000);
        y_now = 482 - 4 * (k / 4);
        h_counter = 10'd455; v_counter = 10'(y_now + 8);
        tick();
        chk("pix_below", 32'({R, G, B}), 32'h000000);
        y_now = 482 - 4 * (k / 4);
        h_counter = 10'd454; v_counter = 10'(y_now);
        tick();
        chk("pix_left", 32'({R, G, B}), 32'h000000);
        fire = 1'b0;

        // Top of screen: 46 -> 42 at k=440, then 42 <= 44 retires at k=444
        while (k < 443) tick();
        chk("top_posy", 32'(posY_Municao), 32'd42);
        chk("top_ativo", 32'(ativo), 32'd1);
        tick();
        chk("retire_ativo", 32'(ativo), 32'd0);
        chk("retire_posy", 32'(posY_Municao), 32'd0);

        // Relaunch on a new edge from ship at X=500
        while (k < 450) tick();
        fire = 1'b1;
        tick();
        tick();
        chk("relaunch_ativo", 32'(ativo), 32'd1);
        chk("relaunch_posx", 32'(posX_Municao), 32'd510);
        chk("relaunch_posy", 32'(posY_Municao), 32'd482);
        fire = 1'b0;

        // Hit together with the step at Y=302: no move to 298
        while (k < 635) tick();
        chk("prehit_posy", 32'(posY_Municao), 32'd302);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("hit_ativo", 32'(ativo), 32'd0);
        chk("hit_posy", 32'(posY_Municao), 32'd0);
        h_counter = 10'd510; v_counter = 10'd302;
`ifdef MUNICAO_EXPLOSAO_EN
        tick();
        chk("exp_yellow", 32'({R, G, B}), 32'hFFFF00);
        tick();
        fire = 1'b1;
        while (k < 645) tick();
        chk("exp_nolaunch", 32'(ativo), 32'd0);
        chk("exp_yellow2", 32'({R, G, B}), 32'hFFFF00);
        fire = 1'b0;
        while (k < 667) tick();
        chk("exp_last", 32'({R, G, B}), 32'hFFFF00);
        while (k < 670) tick();
        chk("exp_done", 32'({R, G, B}), 32'h000000);
`else
        tick();
        chk("hit_black", 32'({R, G, B}), 32'h000000);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("hit_idle", 32'(ativo), 32'd0);
`endif

        // Launch again and reset asynchronously mid-flight
        while (k < 700) tick();
        fire = 1'b1;
        tick();
        tick();
        chk("third_ativo", 32'(ativo), 32'd1);
        chk("third_posy", 32'(posY_Municao), 32'd482);
        fire = 1'b0;
        while (k < 981) tick();
        chk("mid_posy", 32'(posY_Municao), 32'd202);
        h_counter = 10'd510; v_counter = 10'd202;
        tick();
        chk("mid_white", 32'({R, G, B}), 32'hFFFFFF);
        #2 reset = 1'b1;
        #1;
        chk("async_ativo", 32'(ativo), 32'd0);
        chk("async_posx", 32'(posX_Municao), 32'd0);
        chk("async_posy", 32'(posY_Municao), 32'd0);
        chk("async_rgb", 32'({R, G, B}), 32'h000000);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_ativo", 32'(ativo), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
